// File: rtl/cmp_run_monitor.sv
// Program-completion and activity monitor for an N-node CMP: halt detect, drain, watchdog, DMEM access counters.
// Every output is registered or decoded from registered state. The block has no backpressure and only taps its inputs.
module cmp_run_monitor #(
  parameter int                NUM_NODES      = 4,
  parameter int                INST_W         = 32,
  parameter int                CNT_W          = 32,
  parameter logic [INST_W-1:0] HALT_WORD      = '0,
  parameter bit                HALT_STICKY    = 1'b1,
  parameter int                DRAIN_CYCLES   = 30,
  parameter int                TIMEOUT_CYCLES = 13000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_NODES*INST_W-1:0]    node_inst_in,
  input  logic [NUM_NODES-1:0]           node_memEn,
  input  logic [NUM_NODES-1:0]           node_memWrEn,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [NUM_NODES-1:0]           node_halted,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               halt_cycle,
  output logic [NUM_NODES*CNT_W-1:0]     rd_count,
  output logic [NUM_NODES*CNT_W-1:0]     wr_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  // Compare in at least 32 bits so a narrow CNT_W saturates instead of aliasing the limit.
  localparam int TW = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [DW-1:0]          drain_cnt;
  logic [NUM_NODES-1:0]   hit;
  logic                   all_halt;
  logic                   timeout_hit;
  logic                   start_ok;
  logic                   active;
  logic [CNT_W-1:0]       rd_q [NUM_NODES];
  logic [CNT_W-1:0]       wr_q [NUM_NODES];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_NODES; i++)
      hit[i] = (node_inst_in[i*INST_W +: INST_W] == HALT_WORD);
  end

  assign all_halt    = HALT_STICKY ? &(node_halted | hit) : &hit;
  assign timeout_hit = (TW'(cycle_count) == TIMEOUT_LAST);
  assign start_ok    = start && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
  assign active      = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (all_halt)         state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_TIMEOUT;
      end
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = active;
    done    = (state == S_DONE);
    timeout = (state == S_TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      node_halted <= '0;
      cycle_count <= '0;
      halt_cycle  <= '0;
      drain_cnt   <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        rd_q[i] <= '0;
        wr_q[i] <= '0;
      end
    end else if (start_ok) begin
      node_halted <= '0;
      cycle_count <= '0;
      halt_cycle  <= '0;
      drain_cnt   <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        rd_q[i] <= '0;
        wr_q[i] <= '0;
      end
    end else if (active) begin
      cycle_count <= sat_inc(cycle_count, 1'b1);
      for (int i = 0; i < NUM_NODES; i++) begin
        rd_q[i] <= sat_inc(rd_q[i], node_memEn[i] & ~node_memWrEn[i]);
        wr_q[i] <= sat_inc(wr_q[i], node_memEn[i] &  node_memWrEn[i]);
      end
      if (state == S_RUN) begin
        node_halted <= HALT_STICKY ? (node_halted | hit) : hit;
        if (all_halt) begin
          halt_cycle <= cycle_count;
          drain_cnt  <= '0;
        end
      end else begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_pack
    assign rd_count[g*CNT_W +: CNT_W] = rd_q[g];
    assign wr_count[g*CNT_W +: CNT_W] = wr_q[g];
  end

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: default, non-sticky/short-timeout and 4-bit-counter instances share stimulus.
module tb_cmp_run_monitor;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] inst;
  logic [3:0]   mem_en;
  logic [3:0]   mem_wr;

  logic         d_busy, d_done, d_to;
  logic [3:0]   d_nh;
  logic [31:0]  d_cc, d_hc;
  logic [127:0] d_rd, d_wr;

  logic         n_busy, n_done, n_to;
  logic [3:0]   n_nh;
  logic [31:0]  n_cc, n_hc;
  logic [127:0] n_rd, n_wr;

  logic         c_busy, c_done, c_to;
  logic [3:0]   c_nh;
  logic [3:0]   c_cc, c_hc;
  logic [15:0]  c_rd, c_wr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_run_monitor u_dut (
    .clk(clk), .reset(reset), .start(start), .node_inst_in(inst),
    .node_memEn(mem_en), .node_memWrEn(mem_wr),
    .busy(d_busy), .done(d_done), .timeout(d_to), .node_halted(d_nh),
    .cycle_count(d_cc), .halt_cycle(d_hc), .rd_count(d_rd), .wr_count(d_wr)
  );

  cmp_run_monitor #(.HALT_STICKY(1'b0), .TIMEOUT_CYCLES(100)) u_ns (
    .clk(clk), .reset(reset), .start(start), .node_inst_in(inst),
    .node_memEn(mem_en), .node_memWrEn(mem_wr),
    .busy(n_busy), .done(n_done), .timeout(n_to), .node_halted(n_nh),
    .cycle_count(n_cc), .halt_cycle(n_hc), .rd_count(n_rd), .wr_count(n_wr)
  );

  cmp_run_monitor #(.CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .start(start), .node_inst_in(inst),
    .node_memEn(mem_en), .node_memWrEn(mem_wr),
    .busy(c_busy), .done(c_done), .timeout(c_to), .node_halted(c_nh),
    .cycle_count(c_cc), .halt_cycle(c_hc), .rd_count(c_rd), .wr_count(c_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [31:0] n0, input logic [31:0] n1,
                          input logic [31:0] n2, input logic [31:0] n3);
    inst = {n3, n2, n1, n0};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
  endtask

  initial begin
    // Reset with random inputs
    reset  = 1'b0;
    start  = 1'b1;
    inst   = {$urandom, $urandom, $urandom, $urandom};
    mem_en = 4'hF;
    mem_wr = 4'(($urandom));
    tick();
    tick();
    chk("rst_busy", d_busy, 0);
    chk("rst_done", d_done, 0);
    chk("rst_timeout", d_to, 0);
    chk("rst_halted", d_nh, 0);
    chk("rst_cycle", d_cc, 0);
    chk("rst_halt_cycle", d_hc, 0);
    chk("rst_rd", d_rd, 0);
    chk("rst_wr", d_wr, 0);

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      inst   = {$urandom, $urandom, $urandom, $urandom};
      mem_en = 4'($urandom);
      mem_wr = 4'($urandom);
      tick();
    end
    chk("idle_busy", d_busy, 0);
    chk("idle_cycle", d_cc, 0);
    chk("idle_rd", d_rd, 0);

    // Simultaneous halt at RUN cycle 10
    mem_en = 4'h0;
    mem_wr = 4'h0;
    set_inst(32'h11, 32'h22, 32'h33, 32'h44);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sim_start_cycle", d_cc, 0);
    chk("sim_start_busy", d_busy, 1);
    for (int k = 0; k < 10; k++) tick();
    set_inst(0, 0, 0, 0);
    tick();
    chk("sim_halt_cycle", d_hc, 10);
    chk("sim_halted", d_nh, 4'hF);
    chk("sim_drain_busy", d_busy, 1);
    chk("sim_ns_halt_cycle", n_hc, 10);
    set_inst(32'h11, 32'h22, 32'h33, 32'h44);
    for (int k = 0; k < 29; k++) tick();
    chk("sim_drain29_busy", d_busy, 1);
    chk("sim_drain29_done", d_done, 0);
    tick();
    chk("sim_done", d_done, 1);
    chk("sim_done_busy", d_busy, 0);
    chk("sim_final_cycle", d_cc, 41);

    // Start in DONE, start mid-RUN, reset mid-DRAIN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_cycle", d_cc, 0);
    chk("restart_halt_cycle", d_hc, 0);
    chk("restart_halted", d_nh, 0);
    chk("restart_busy", d_busy, 1);
    for (int k = 0; k < 5; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrun_start_cycle", d_cc, 6);
    chk("midrun_start_busy", d_busy, 1);
    set_inst(0, 0, 0, 0);
    tick();
    chk("midrun_halt_cycle", d_hc, 6);
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    #1;
    chk("drain_rst_busy", d_busy, 0);
    chk("drain_rst_done", d_done, 0);
    chk("drain_rst_cycle", d_cc, 0);
    chk("drain_rst_halt_cycle", d_hc, 0);
    chk("drain_rst_halted", d_nh, 0);
    tick();
    reset = 1'b1;

    // Staggered halt: sticky instance completes, non-sticky instance times out
    set_inst(32'h11, 32'h22, 32'h33, 32'h44);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      set_inst((k == 5) ? 32'h0 : 32'h11,
               (k >= 12) ? 32'h0 : 32'h22,
               (k >= 12) ? 32'h0 : 32'h33,
               (k >= 20) ? 32'h0 : 32'h44);
      tick();
      if (k == 6) begin
        chk("stag_sticky_halted6", d_nh, 4'b0001);
        chk("stag_nonsticky_halted6", n_nh, 4'b0000);
      end
      if (k == 20) begin
        chk("stag_halt_cycle", d_hc, 20);
        chk("stag_halted", d_nh, 4'hF);
        chk("stag_drain_busy", d_busy, 1);
      end
    end
    chk("stag_sticky_done", d_done, 1);
    chk("stag_sticky_cycle", d_cc, 51);
    chk("ns_timeout", n_to, 1);
    chk("ns_cycle", n_cc, 100);
    chk("ns_done", n_done, 0);
    chk("ns_busy", n_busy, 0);
    chk("ns_halted", n_nh, 4'b1110);

    // Access counters and saturation
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_inst(32'h11, 32'h22, 32'h33, 32'h44);
    mem_en = 4'h0;
    mem_wr = 4'h0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mem_wr = 4'hF;
    tick();
    mem_en = 4'b0010;
    mem_wr = 4'b0010;
    for (int k = 0; k < 7; k++) tick();
    mem_wr = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    mem_en = 4'h0;
    tick();
    chk("cnt4_wr", c_wr, 16'h0070);
    chk("cnt4_rd", c_rd, 16'h0030);
    chk("cnt32_wr", d_wr, {32'd0, 32'd0, 32'd7, 32'd0});
    mem_en = 4'b0001;
    for (int k = 0; k < 20; k++) tick();
    mem_en = 4'h0;
    tick();
    chk("cnt4_rd_sat", c_rd, 16'h003F);
    chk("cnt32_rd", d_rd, {32'd0, 32'd0, 32'd3, 32'd20});
    chk("cnt4_busy", c_busy, 1);
    chk("cnt4_cycle_sat", c_cc, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_run_monitor.md
Name: cmp_run_monitor

Overview:
Synthesizable, parametrised N-node program-completion and activity monitor for the cardinal CMP. It moves the bench's "all nodes fetched the halt word, then flush" check on-chip, adding per-node data-memory access counters. It adds a selectable halt-detection mode and a watchdog timeout. It sits beside cardinal_cmp and taps each node's instruction input and DMEM enables without altering them.

Parameters:
NUM_NODES, 4, number of CPU nodes monitored
INST_W, 32, instruction width per node
CNT_W, 32, width of cycle and access counters (all saturating)
HALT_WORD, 32'h00000000, instruction value that marks end of program
HALT_STICKY, 1, 1: per-node halt latches once seen; 0: all nodes must show HALT_WORD in the same cycle
DRAIN_CYCLES, 30, pipeline-flush cycles after halt before done (must be >= 1)
TIMEOUT_CYCLES, 13000, RUN-state cycle limit before timeout (must be >= 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin a monitored run; honoured only in IDLE, DONE or TIMEOUT
node_inst_in  in  NUM_NODES*INST_W  instruction fetched per node; node i = bits [i*INST_W +: INST_W]
node_memEn  in  NUM_NODES  per-node DMEM enable
node_memWrEn  in  NUM_NODES  per-node DMEM write enable
busy  out  1  high in RUN or DRAIN
done  out  1  level, high in DONE
timeout  out  1  level, high in TIMEOUT
node_halted  out  NUM_NODES  per-node halt status
cycle_count  out  CNT_W  cycles elapsed since start
halt_cycle  out  CNT_W  cycle_count value at the all-halted detection edge
rd_count  out  NUM_NODES*CNT_W  per-node DMEM reads (memEn & !memWrEn)
wr_count  out  NUM_NODES*CNT_W  per-node DMEM writes (memEn & memWrEn)

Behaviour:
- Reset (reset=0, async): state IDLE; every output and counter 0; drain counter 0.
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start=1 at an edge -> RUN. Same edge clears cycle_count, halt_cycle, node_halted, rd/wr counts and the drain counter to 0.
- start in RUN or DRAIN: ignored.
- hit[i] = (node_inst_in slice i == HALT_WORD).
- In RUN, each edge: node_halted <= HALT_STICKY ? (node_halted | hit) : hit.
- all_halt = HALT_STICKY ? &(node_halted | hit) : &hit. It is evaluated combinationally from the current cycle's inputs.
- RUN edge with all_halt: halt_cycle <= cycle_count (pre-increment value); state -> DRAIN; drain counter <= 0.
- RUN edge with !all_halt and cycle_count == TIMEOUT_CYCLES-1: state -> TIMEOUT.
- all_halt has priority over timeout on the same edge.
- DRAIN: drain counter increments each edge. The edge where it equals DRAIN_CYCLES-1 -> DONE, so DRAIN lasts exactly DRAIN_CYCLES cycles. No timeout applies in DRAIN. node_halted is frozen.
- cycle_count increments (saturating at 2^CNT_W-1) on every edge where the current state is RUN or DRAIN. It freezes in DONE/TIMEOUT.
  - Final value at DONE = halt_cycle + 1 + DRAIN_CYCLES.
  - At TIMEOUT = TIMEOUT_CYCLES.
- rd_count/wr_count update on edges in RUN or DRAIN only, each saturating at 2^CNT_W-1. memEn=0 counts nothing; memWrEn alone is ignored.
- Outputs are registered or decoded from registered state; no combinational path from node inputs to outputs.
- Reset asserted mid-RUN/DRAIN: immediate return to IDLE with all outputs 0.

Test Plan:
- Reset values: reset=0 with random inputs -> busy=done=timeout=0, all counters and node_halted 0. Raise reset with no start -> remains IDLE for 50 cycles.
- Simultaneous halt (defaults): start, non-zero instructions for RUN cycles 0..9, all four = 0 at cycle 10 -> halt_cycle=10, node_halted=4'b1111. DRAIN holds busy for 30 cycles, then done=1 and cycle_count=41.
- Staggered halt, HALT_STICKY=1: node0 = 0 only at cycle 5, node3 first 0 at cycle 20, others 0 from cycle 12 -> halt_cycle=20.
- Staggered halt, HALT_STICKY=0, TIMEOUT_CYCLES=100: same stimulus never completes -> timeout=1, cycle_count=100, done=0.
- Access counters, CNT_W=4: node1 memEn=1,memWrEn=1 for 7 cycles, then memEn=1,memWrEn=0 for 3 cycles -> wr_count[1]=7, rd_count[1]=3, others 0. A 20-cycle read burst -> rd_count saturates at 15.
- Control corners:
  - start pulsed mid-RUN -> no counter clear.
  - reset=0 mid-DRAIN -> all outputs 0 immediately, IDLE.
  - start in DONE -> counters cleared and a new run begins with cycle_count=0.
